// File: rtl/led128_mask_frontend.sv
// led128_mask_frontend
// Masking front end for a three-share LED128 core. It takes an unmasked
// plaintext/key pair, splits each into three Boolean shares using a 64-bit
// xorshift PRNG, feeds the shares through a core reset/prime sequence, then
// recombines the ciphertext shares when the core reports done. If the core
// stalls, the request is abandoned with a one-cycle err pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; pt (64b) and key (128b) sampled on accept
//   Plaintext0/1/2, Key0/1/2 share outputs to the core
//   r                        72 bits of fresh randomness to the core, refreshed every cycle
//   core_rst                 core reset; low only while the core is running
//   Ciphertext0/1/2, done    ciphertext shares and completion from the core
//   ct, out_valid            recombined ciphertext and its one-cycle valid strobe
//   err                      one-cycle strobe when the core times out
module led128_mask_frontend #(
    parameter logic [63:0] SEED_A  = 64'h0123456789ABCDEF,
    parameter logic [63:0] SEED_B  = 64'hFEDCBA9876543210,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  pt,
    input  logic [127:0] key,
    output logic [63:0]  Plaintext0,
    output logic [63:0]  Plaintext1,
    output logic [63:0]  Plaintext2,
    output logic [127:0] Key0,
    output logic [127:0] Key1,
    output logic [127:0] Key2,
    output logic [71:0]  r,
    output logic         core_rst,
    input  logic [63:0]  Ciphertext0,
    input  logic [63:0]  Ciphertext1,
    input  logic [63:0]  Ciphertext2,
    input  logic         done,
    output logic [63:0]  ct,
    output logic         out_valid,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, MASK, PRIME, RUN} state_t;

    function automatic logic [63:0] xs64(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    state_t       state, state_n;
    logic [2:0]   cnt, cnt_n;          // MASK slot index (0..5), reused as PRIME cycle count (0..2)
    logic [31:0]  tcnt, tcnt_n;        // RUN cycles seen without done
    logic [63:0]  prng_a, prng_b, a_next, b_next;
    logic [63:0]  pt_q, p1, p2, k2_hi;
    logic [127:0] key_q, k1;
    logic         accept, mask_step, load, fire_ok, fire_err;

    assign a_next   = xs64(prng_a);
    assign b_next   = xs64(prng_b);
    assign in_ready = (state == IDLE);
    assign core_rst = (state != RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and control strobes
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tcnt_n    = tcnt;
        accept    = 1'b0;
        mask_step = 1'b0;
        load      = 1'b0;
        fire_ok   = 1'b0;
        fire_err  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = MASK;
                    cnt_n   = 3'd0;
                end
            end
            MASK: begin
                mask_step = 1'b1;
                if (cnt == 3'd5) begin
                    load    = 1'b1;
                    state_n = PRIME;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            PRIME: begin
                if (cnt == 3'd2) begin
                    state_n = RUN;
                    cnt_n   = 3'd0;
                    tcnt_n  = 32'd0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            RUN: begin
                if (done) begin
                    fire_ok = 1'b1;
                    state_n = IDLE;
                    tcnt_n  = 32'd0;
                end else if (tcnt == TIMEOUT) begin
                    fire_err = 1'b1;
                    state_n  = IDLE;
                    tcnt_n   = 32'd0;
                end else begin
                    tcnt_n = tcnt + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            tcnt       <= '0;
            prng_a     <= SEED_A;
            prng_b     <= SEED_B;
            r          <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            p1         <= '0;
            p2         <= '0;
            k1         <= '0;
            k2_hi      <= '0;
            Plaintext0 <= '0;
            Plaintext1 <= '0;
            Plaintext2 <= '0;
            Key0       <= '0;
            Key1       <= '0;
            Key2       <= '0;
            ct         <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            tcnt      <= tcnt_n;
            prng_a    <= a_next;
            prng_b    <= b_next;
            r         <= {b_next[7:0], a_next};
            out_valid <= fire_ok;
            err       <= fire_err;

            if (accept) begin
                pt_q  <= pt;
                key_q <= key;
            end

            // The last mask word (K2 low half) is consumed directly from
            // a_next on the load edge, so it never needs its own register.
            if (mask_step) begin
                case (cnt)
                    3'd0:    p1          <= a_next;
                    3'd1:    p2          <= a_next;
                    3'd2:    k1[127:64]  <= a_next;
                    3'd3:    k1[63:0]    <= a_next;
                    3'd4:    k2_hi       <= a_next;
                    default: ;
                endcase
            end

            if (load) begin
                Plaintext1 <= p1;
                Plaintext2 <= p2;
                Plaintext0 <= pt_q ^ p1 ^ p2;
                Key1       <= k1;
                Key2       <= {k2_hi, a_next};
                Key0       <= key_q ^ k1 ^ {k2_hi, a_next};
                // Unmasked secrets are not kept once the shares exist.
                pt_q       <= '0;
                key_q      <= '0;
            end

            if (fire_ok)
                ct <= Ciphertext0 ^ Ciphertext1 ^ Ciphertext2;
        end
    end

endmodule

// File: doc/led128_mask_frontend.md
LED128_MASK_FRONTEND -- requirements
Module: led128_mask_frontend

Interface
REQ-001 The block SHALL have parameter SEED_A, default 64'h0123456789ABCDEF, initial state of PRNG A (nonzero).
REQ-002 The block SHALL have parameter SEED_B, default 64'hFEDCBA9876543210, initial state of PRNG B (nonzero).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum RUN cycles waiting for core done.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk  in  1  rising-edge clock.
REQ-006 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have port in_valid  in  1  request valid.
REQ-008 The block SHALL have port in_ready  out  1  block ready to accept.
REQ-009 The block SHALL have port pt  in  64  unmasked plaintext.
REQ-010 The block SHALL have port key  in  128  unmasked key.
REQ-011 The block SHALL have ports Plaintext0/1/2  out  64 each  plaintext shares to the LED128 core.
REQ-012 The block SHALL have ports Key0/1/2  out  128 each  key shares to the core.
REQ-013 The block SHALL have port r  out  72  fresh randomness to the core.
REQ-014 The block SHALL have port core_rst  out  1  reset driven to the core's rst.
REQ-015 The block SHALL have ports Ciphertext0/1/2  in  64 each  ciphertext shares from the core.
REQ-016 The block SHALL have port done  in  1  core done.
REQ-017 The block SHALL have port ct  out  64  unmasked ciphertext.
REQ-018 The block SHALL have port out_valid  out  1  one-cycle ct valid pulse.
REQ-019 The block SHALL have port err  out  1  one-cycle timeout pulse.

Function
REQ-020 The block SHALL implement two xorshift64 PRNGs, A and B, each stepping every cycle: s^=s<<13; s^=s>>7; s^=s<<17.
REQ-021 The block SHALL register r <= {B_next[7:0], A_next} every cycle in every state.
REQ-022 The block SHALL implement FSM states IDLE, MASK, PRIME, RUN.
REQ-023 The block SHALL drive in_ready=1 only in IDLE; acceptance is in_valid&in_ready at an edge E0, which latches pt/key and enters MASK; in_valid outside IDLE is ignored.
REQ-024 In MASK, edges E1..E6 SHALL store A_next into slots P1, P2, K1[127:64], K1[63:0], K2[127:64], K2[63:0] in that order (3-bit counter 0..5).
REQ-025 At E6 the block SHALL load Plaintext1=P1, Plaintext2=P2, Plaintext0=pt^P1^P2, Key1=K1, Key2=K2, Key0=key^K1^K2, zeroize the pt/key latches, and enter PRIME.
REQ-026 Share outputs SHALL hold stable from E6 until the next acceptance or reset.
REQ-027 PRIME SHALL last 3 cycles with core_rst=1 (pipeline load); at E9 the block SHALL set core_rst=0 and enter RUN.
REQ-028 In RUN, the first cycle with done=1 SHALL register ct <= Ciphertext0^Ciphertext1^Ciphertext2, pulse out_valid for one cycle, set core_rst=1, and return to IDLE.
REQ-029 In RUN, if done stays 0 for TIMEOUT+1 cycles, the block SHALL pulse err for one cycle, set core_rst=1, and return to IDLE; ct is unchanged.
REQ-030 core_rst SHALL be 1 in IDLE, MASK and PRIME.
REQ-031 out_valid and err SHALL never be asserted in the same cycle.
REQ-032 ct SHALL hold its value between out_valid pulses.

Reset
REQ-033 On rst=1 the block SHALL set state=IDLE, A=SEED_A, B=SEED_B, r=0, all share outputs=0, ct=0, pt/key latches=0, all counters=0, core_rst=1, in_ready=1 (from next cycle), out_valid=0, err=0.
REQ-034 rst SHALL override all states, including mid-MASK and mid-RUN; a partially masked request is discarded with no out_valid.

Verification
REQ-035 Reset check: hold rst=1 for 2 cycles, then release -> in_ready=1, core_rst=1, out_valid=0, err=0, r=0, Plaintext0..2=0, then r changes every cycle.
REQ-036 Known answer: pt=64'h0123456789ABCDEF, key=128'h0123456789ABCDEF0123456789ABCDEF with a reference LED128 core -> exactly one out_valid with ct=64'hD6B824587F014FC2; Plaintext0^1^2=pt and Key0^1^2=key from E6 onward; Plaintext1!=0.
REQ-037 Timing: core_rst falls at E9 after acceptance; in_ready=0 from E0 until the return to IDLE; in_valid pulses meanwhile do not alter the shares.
REQ-038 Timeout: stub core with done tied 0 -> err pulses once after 256 RUN cycles, state returns to IDLE, ct unchanged, out_valid stays 0.
REQ-039 Reset mid-RUN: rst at E12 -> next cycle in IDLE, shares=0, core_rst=1; a new request then completes with a correct ct.
REQ-040 Back-to-back: second request accepted on the cycle after out_valid -> masks differ from the first request; ct is still correct.
